// File: rtl/ysyx_24080006_mem_arbiter.sv
// Two-requester (IFU read-only, LSU read/write) single-beat AXI4 arbiter.
// Define ARB_PERF_CNT_EN to build the grant/wait performance counters.
package ysyx_24080006_axi_pkg;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic [3:0]  rid;
    } axi_r_s2m_t;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [3:0]  awid;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
        logic [3:0]  bid;
    } axi_w_s2m_t;

endpackage

module ysyx_24080006_mem_arbiter
    import ysyx_24080006_axi_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  axi_r_m2s_t  ifu_r_m2s,
    output axi_r_s2m_t  ifu_r_s2m,
    input  axi_r_m2s_t  lsu_r_m2s,
    output axi_r_s2m_t  lsu_r_s2m,
    input  axi_w_m2s_t  lsu_w_m2s,
    output axi_w_s2m_t  lsu_w_s2m,
    output axi_r_m2s_t  mem_r_m2s,
    input  axi_r_s2m_t  mem_r_s2m,
    output axi_w_m2s_t  mem_w_m2s,
    input  axi_w_s2m_t  mem_w_s2m,
    output logic [31:0] perf_ifu_grants,
    output logic [31:0] perf_lsu_grants,
    output logic [31:0] perf_wait_cycles
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IFU_RD,
        ARB_LSU_RD,
        ARB_LSU_WR
    } arb_state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state;
    arb_state_t grant_sel;
    logic       ar_done;
    logic       aw_done;
    logic       w_done;
    logic [3:0] starve_cnt;

    logic ifu_pend;
    logic lsu_rd_pend;
    logic lsu_wr_pend;
    logic starve_hit;
    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign ifu_pend    = ifu_r_m2s.arvalid;
    assign lsu_rd_pend = lsu_r_m2s.arvalid;
    assign lsu_wr_pend = lsu_w_m2s.awvalid | lsu_w_m2s.wvalid;
    assign starve_hit  = ifu_pend && (starve_cnt == LIMIT);

    assign ar_hs = mem_r_m2s.arvalid & mem_r_s2m.arready;
    assign r_hs  = mem_r_s2m.rvalid  & mem_r_m2s.rready;
    assign aw_hs = mem_w_m2s.awvalid & mem_w_s2m.awready;
    assign w_hs  = mem_w_m2s.wvalid  & mem_w_s2m.wready;
    assign b_hs  = mem_w_s2m.bvalid  & mem_w_m2s.bready;

    always_comb begin
        grant_sel = ARB_IDLE;
        if (starve_hit) begin
            grant_sel = ARB_IFU_RD;
        end else if (lsu_wr_pend) begin
            grant_sel = ARB_LSU_WR;
        end else if (lsu_rd_pend) begin
            grant_sel = ARB_LSU_RD;
        end else if (ifu_pend) begin
            grant_sel = ARB_IFU_RD;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB_IDLE;
            ar_done    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    state   <= grant_sel;
                    ar_done <= 1'b0;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (grant_sel == ARB_IFU_RD) begin
                        starve_cnt <= '0;
                    end else if (grant_sel != ARB_IDLE) begin
                        // LSU grant: count only while the IFU is left waiting
                        if (!ifu_pend) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt < LIMIT) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                ARB_IFU_RD, ARB_LSU_RD: begin
                    if (ar_hs) begin
                        ar_done <= 1'b1;
                    end
                    if (r_hs) begin
                        state   <= ARB_IDLE;
                        ar_done <= 1'b0;
                    end
                end
                ARB_LSU_WR: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if (b_hs) begin
                        state   <= ARB_IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Routing depends on state only; in ARB_IDLE every output is constant zero.
    always_comb begin
        mem_r_m2s = '0;
        mem_w_m2s = '0;
        ifu_r_s2m = '0;
        lsu_r_s2m = '0;
        lsu_w_s2m = '0;
        unique case (state)
            ARB_IFU_RD: begin
                mem_r_m2s         = ifu_r_m2s;
                mem_r_m2s.arvalid = ifu_r_m2s.arvalid & ~ar_done;
                ifu_r_s2m         = mem_r_s2m;
                ifu_r_s2m.arready = mem_r_s2m.arready & ~ar_done;
            end
            ARB_LSU_RD: begin
                mem_r_m2s         = lsu_r_m2s;
                mem_r_m2s.arvalid = lsu_r_m2s.arvalid & ~ar_done;
                lsu_r_s2m         = mem_r_s2m;
                lsu_r_s2m.arready = mem_r_s2m.arready & ~ar_done;
            end
            ARB_LSU_WR: begin
                mem_w_m2s         = lsu_w_m2s;
                mem_w_m2s.awvalid = lsu_w_m2s.awvalid & ~aw_done;
                mem_w_m2s.wvalid  = lsu_w_m2s.wvalid & ~w_done;
                lsu_w_s2m         = mem_w_s2m;
                lsu_w_s2m.awready = mem_w_s2m.awready & ~aw_done;
                lsu_w_s2m.wready  = mem_w_s2m.wready & ~w_done;
            end
            default: ;
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] ifu_grants_q;
    logic [31:0] lsu_grants_q;
    logic [31:0] wait_cycles_q;
    logic        lsu_pend;
    logic        waiting;

    assign lsu_pend = lsu_rd_pend | lsu_wr_pend;
    assign waiting  = (ifu_pend && state != ARB_IFU_RD) ||
                      (lsu_pend && state != ARB_LSU_RD && state != ARB_LSU_WR);

    always_ff @(posedge clock) begin
        if (reset) begin
            ifu_grants_q  <= '0;
            lsu_grants_q  <= '0;
            wait_cycles_q <= '0;
        end else begin
            if (state == ARB_IDLE && grant_sel == ARB_IFU_RD) begin
                ifu_grants_q <= ifu_grants_q + 32'd1;
            end
            if (state == ARB_IDLE && (grant_sel == ARB_LSU_RD || grant_sel == ARB_LSU_WR)) begin
                lsu_grants_q <= lsu_grants_q + 32'd1;
            end
            if (waiting) begin
                wait_cycles_q <= wait_cycles_q + 32'd1;
            end
        end
    end

    assign perf_ifu_grants  = ifu_grants_q;
    assign perf_lsu_grants  = lsu_grants_q;
    assign perf_wait_cycles = wait_cycles_q;
`else
    assign perf_ifu_grants  = '0;
    assign perf_lsu_grants  = '0;
    assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_ysyx_24080006_mem_arbiter.sv
// Directed bench for ysyx_24080006_mem_arbiter (STARVE_LIMIT = 2); perf checks follow ARB_PERF_CNT_EN.
module tb_ysyx_24080006_mem_arbiter;
    import ysyx_24080006_axi_pkg::*;

`ifdef ARB_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    axi_r_m2s_t  ifu_r_m2s, lsu_r_m2s, mem_r_m2s;
    axi_r_s2m_t  ifu_r_s2m, lsu_r_s2m, mem_r_s2m;
    axi_w_m2s_t  lsu_w_m2s, mem_w_m2s;
    axi_w_s2m_t  lsu_w_s2m, mem_w_s2m;
    logic [31:0] perf_ifu_grants, perf_lsu_grants, perf_wait_cycles;

    int n_vec = 0;
    int n_err = 0;

    ysyx_24080006_mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .ifu_r_m2s        (ifu_r_m2s),
        .ifu_r_s2m        (ifu_r_s2m),
        .lsu_r_m2s        (lsu_r_m2s),
        .lsu_r_s2m        (lsu_r_s2m),
        .lsu_w_m2s        (lsu_w_m2s),
        .lsu_w_s2m        (lsu_w_s2m),
        .mem_r_m2s        (mem_r_m2s),
        .mem_r_s2m        (mem_r_s2m),
        .mem_w_m2s        (mem_w_m2s),
        .mem_w_s2m        (mem_w_s2m),
        .perf_ifu_grants  (perf_ifu_grants),
        .perf_lsu_grants  (perf_lsu_grants),
        .perf_wait_cycles (perf_wait_cycles)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perf_exp(input logic [31:0] n);
        return PERF_ON ? n : 32'd0;
    endfunction

    // Starts in ARB_IDLE; IFU must win the next edge. Data returns two idle cycles after AR.
    task automatic ifu_read(input logic [31:0] addr, input logic [31:0] data, input string tag);
        ifu_r_m2s.arvalid = 1'b1;
        ifu_r_m2s.araddr  = addr;
        #1;
        chk1({tag, "_idle_no_arvalid"}, mem_r_m2s.arvalid, 1'b0);
        chk1({tag, "_idle_no_arready"}, ifu_r_s2m.arready, 1'b0);
        step();
        chk1({tag, "_mem_arvalid"}, mem_r_m2s.arvalid, 1'b1);
        chk32({tag, "_mem_araddr"}, mem_r_m2s.araddr, addr);
        mem_r_s2m.arready = 1'b1;
        #1;
        chk1({tag, "_ifu_arready"}, ifu_r_s2m.arready, 1'b1);
        chk1({tag, "_lsu_no_arready"}, lsu_r_s2m.arready, 1'b0);
        step();
        ifu_r_m2s.arvalid = 1'b0;
        mem_r_s2m.arready = 1'b0;
        #1;
        chk1({tag, "_arvalid_after_hs"}, mem_r_m2s.arvalid, 1'b0);
        step();
        step();
        mem_r_s2m.rvalid = 1'b1;
        mem_r_s2m.rdata  = data;
        mem_r_s2m.rresp  = 2'b00;
        #1;
        chk1({tag, "_ifu_rvalid"}, ifu_r_s2m.rvalid, 1'b1);
        chk32({tag, "_ifu_rdata"}, ifu_r_s2m.rdata, data);
        chk1({tag, "_lsu_no_rvalid"}, lsu_r_s2m.rvalid, 1'b0);
        step();
        mem_r_s2m.rvalid = 1'b0;
    endtask

    // Starts in ARB_IDLE; LSU must win the next edge (IFU may be left pending).
    task automatic lsu_read(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] resp, input string tag);
        lsu_r_m2s.arvalid = 1'b1;
        lsu_r_m2s.araddr  = addr;
        #1;
        chk1({tag, "_idle_no_arvalid"}, mem_r_m2s.arvalid, 1'b0);
        step();
        chk1({tag, "_mem_arvalid"}, mem_r_m2s.arvalid, 1'b1);
        chk32({tag, "_mem_araddr"}, mem_r_m2s.araddr, addr);
        mem_r_s2m.arready = 1'b1;
        #1;
        chk1({tag, "_lsu_arready"}, lsu_r_s2m.arready, 1'b1);
        chk1({tag, "_ifu_no_arready"}, ifu_r_s2m.arready, 1'b0);
        step();
        lsu_r_m2s.arvalid = 1'b0;
        mem_r_s2m.arready = 1'b0;
        mem_r_s2m.rvalid  = 1'b1;
        mem_r_s2m.rdata   = data;
        mem_r_s2m.rresp   = resp;
        #1;
        chk1({tag, "_lsu_rvalid"}, lsu_r_s2m.rvalid, 1'b1);
        chk32({tag, "_lsu_rdata"}, lsu_r_s2m.rdata, data);
        chk32({tag, "_lsu_rresp"}, 32'(lsu_r_s2m.rresp), 32'(resp));
        chk1({tag, "_ifu_no_rvalid"}, ifu_r_s2m.rvalid, 1'b0);
        step();
        mem_r_s2m.rvalid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        ifu_r_m2s = '0;
        lsu_r_m2s = '0;
        lsu_w_m2s = '0;
        mem_r_s2m = '0;
        mem_w_s2m = '0;
        ifu_r_m2s.rready = 1'b1;
        lsu_r_m2s.rready = 1'b1;
        lsu_w_m2s.bready = 1'b1;
        repeat (3) step();
        chk1("rst_mem_arvalid", mem_r_m2s.arvalid, 1'b0);
        chk1("rst_mem_rready", mem_r_m2s.rready, 1'b0);
        chk1("rst_mem_awvalid", mem_w_m2s.awvalid, 1'b0);
        chk1("rst_mem_wvalid", mem_w_m2s.wvalid, 1'b0);
        chk32("rst_perf_ifu", perf_ifu_grants, 32'd0);
        chk32("rst_perf_lsu", perf_lsu_grants, 32'd0);
        chk32("rst_perf_wait", perf_wait_cycles, 32'd0);
        reset = 1'b0;
        step();

        // IFU alone
        ifu_read(32'h3000_0000, 32'hDEAD_BEEF, "t1");
        chk32("t1_perf_ifu", perf_ifu_grants, perf_exp(32'd1));
        chk32("t1_perf_lsu", perf_lsu_grants, perf_exp(32'd0));
        chk32("t1_perf_wait", perf_wait_cycles, perf_exp(32'd1));

        // IFU and LSU together: LSU first, then IFU
        ifu_r_m2s.arvalid = 1'b1;
        ifu_r_m2s.araddr  = 32'h3000_0004;
        lsu_read(32'h8000_0100, 32'h1111_1111, 2'b00, "t2_lsu");
        ifu_read(32'h3000_0004, 32'h2222_2222, "t2_ifu");
        chk32("t2_perf_ifu", perf_ifu_grants, perf_exp(32'd2));
        chk32("t2_perf_lsu", perf_lsu_grants, perf_exp(32'd1));

        // LSU write, awready two cycles ahead of wready
        lsu_w_m2s.awvalid = 1'b1;
        lsu_w_m2s.awaddr  = 32'h8000_0010;
        lsu_w_m2s.wvalid  = 1'b1;
        lsu_w_m2s.wdata   = 32'h1234_5678;
        lsu_w_m2s.wstrb   = 4'hF;
        #1;
        chk1("t3_idle_no_awvalid", mem_w_m2s.awvalid, 1'b0);
        step();
        chk1("t3_mem_awvalid", mem_w_m2s.awvalid, 1'b1);
        chk1("t3_mem_wvalid", mem_w_m2s.wvalid, 1'b1);
        chk32("t3_mem_awaddr", mem_w_m2s.awaddr, 32'h8000_0010);
        chk32("t3_mem_wdata", mem_w_m2s.wdata, 32'h1234_5678);
        chk32("t3_mem_wstrb", 32'(mem_w_m2s.wstrb), 32'hF);
        chk1("t3_no_mem_arvalid", mem_r_m2s.arvalid, 1'b0);
        mem_w_s2m.awready = 1'b1;
        #1;
        chk1("t3_lsu_awready", lsu_w_s2m.awready, 1'b1);
        chk1("t3_lsu_no_wready", lsu_w_s2m.wready, 1'b0);
        step();
        lsu_w_m2s.awvalid = 1'b0;
        mem_w_s2m.awready = 1'b0;
        #1;
        chk1("t3_awvalid_dropped", mem_w_m2s.awvalid, 1'b0);
        chk1("t3_wvalid_held", mem_w_m2s.wvalid, 1'b1);
        step();
        mem_w_s2m.wready = 1'b1;
        #1;
        chk1("t3_lsu_wready", lsu_w_s2m.wready, 1'b1);
        step();
        lsu_w_m2s.wvalid = 1'b0;
        mem_w_s2m.wready = 1'b0;
        mem_w_s2m.bvalid = 1'b1;
        mem_w_s2m.bresp  = 2'b00;
        #1;
        chk1("t3_wvalid_dropped", mem_w_m2s.wvalid, 1'b0);
        chk1("t3_mem_bready", mem_w_m2s.bready, 1'b1);
        chk1("t3_lsu_bvalid", lsu_w_s2m.bvalid, 1'b1);
        step();
        mem_w_s2m.bvalid = 1'b0;
        #1;
        chk1("t3_idle_no_bready", mem_w_m2s.bready, 1'b0);
        chk1("t3_idle_no_bvalid", lsu_w_s2m.bvalid, 1'b0);

        // Starvation guard: IFU pending, LSU back-to-back; IFU wins after 2 LSU grants
        ifu_r_m2s.arvalid = 1'b1;
        ifu_r_m2s.araddr  = 32'h3000_0040;
        lsu_read(32'h8000_0200, 32'hA000_0001, 2'b00, "t4_lsu1");
        lsu_read(32'h8000_0204, 32'hA000_0002, 2'b00, "t4_lsu2");
        lsu_r_m2s.arvalid = 1'b1;
        lsu_r_m2s.araddr  = 32'h8000_0208;
        ifu_read(32'h3000_0040, 32'hB000_0003, "t4_ifu");

        // Error response on the deferred LSU read, then the next request is served
        lsu_read(32'h8000_0208, 32'hBAD0_BAD0, 2'b10, "t5_lsu_err");
        ifu_read(32'h3000_0080, 32'hC000_0004, "t5_next");
        chk32("t5_perf_ifu", perf_ifu_grants, perf_exp(32'd4));
        chk32("t5_perf_lsu", perf_lsu_grants, perf_exp(32'd5));

        // Reset in ARB_LSU_RD after AR handshake
        lsu_r_m2s.arvalid = 1'b1;
        lsu_r_m2s.araddr  = 32'h8000_0300;
        step();
        mem_r_s2m.arready = 1'b1;
        step();
        lsu_r_m2s.arvalid = 1'b0;
        mem_r_s2m.arready = 1'b0;
        #1;
        chk1("t6_pre_rready", mem_r_m2s.rready, 1'b1);
        reset = 1'b1;
        step();
        chk1("t6_mem_arvalid", mem_r_m2s.arvalid, 1'b0);
        chk1("t6_mem_rready", mem_r_m2s.rready, 1'b0);
        chk1("t6_mem_awvalid", mem_w_m2s.awvalid, 1'b0);
        chk1("t6_mem_wvalid", mem_w_m2s.wvalid, 1'b0);
        chk32("t6_perf_ifu", perf_ifu_grants, 32'd0);
        chk32("t6_perf_lsu", perf_lsu_grants, 32'd0);
        chk32("t6_perf_wait", perf_wait_cycles, 32'd0);
        reset = 1'b0;
        step();
        ifu_read(32'h3000_0100, 32'h5555_AAAA, "t6_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
